dcc_frame_scheduler: RTL
========================

// Module: dcc_frame_scheduler
// PURPOSE
//  Sequences DCC packets from the centrale_DCC_IP register bank to the DCC bit serializer.
//  Holds NUM_SLOTS command slots (address+command, loaded by AXI4-Lite register writes).
//  - Round-robin selects a pending slot; each slot is sent REPEAT times.
//  - Adds an XOR checksum and enforces an inter-packet gap.
//  - Sends DCC idle packets when nothing is pending.
// PARAMETERS
//  NUM_SLOTS   4    number of command slots (2..8)
//  REPEAT      3    transmissions per slot write (1..15)
//  GAP_CYCLES  100  ACLK cycles between frame acceptance and next selection (0 = none)
//  IDLE_EN     1    1: send idle packet when no slot is pending; 0: stay silent
// PORTS
//  ACLK          in   1          clock
//  ARESETN       in   1          synchronous reset, active low
//  enable        in   1          scheduler run enable (register bit)
//  slot_wr       in   NUM_SLOTS  per-slot load strobe, 1 cycle; several bits may be set
//  slot_addr     in   8          DCC address byte, loaded on slot_wr
//  slot_cmd      in   8          DCC instruction byte, loaded on slot_wr
//  slot_pending  out  NUM_SLOTS  bit i = slot i has repeats remaining
//  frame_valid   out  1          frame offered to serializer
//  frame_ready   in   1          serializer accepts frame
//  frame_data    out  24         {addr, cmd, addr^cmd}
//  frame_is_idle out  1          offered frame is the idle packet
//  frame_slot    out  clog2(N)   slot index of offered frame (0 when idle)
//  frames_sent   out  16         accepted-frame counter, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (ARESETN=0 at a rising edge):
//   - all outputs 0; all rep_cnt 0; rr pointer = NUM_SLOTS-1; state SELECT.
//   - Reset mid-offer drops frame_valid on that edge, regardless of frame_ready.
//  Slot load: slot_wr[i] -> addr/cmd[i] <= inputs, rep_cnt[i] <= REPEAT.
//   - slot_pending[i] = (rep_cnt[i]!=0), registered, visible the cycle after the write.
//  FSM states: SELECT, OFFER, GAP.
//  SELECT:
//   - enable=0: stay.
//   - A slot is pending: pick the first pending index searching ptr+1, ptr+2, ... (mod N).
//     Register frame_data, frame_slot and frame_is_idle=0, set frame_valid, go to OFFER.
//   - No slot pending and IDLE_EN=1: frame_data=24'hFF_00_FF, frame_is_idle=1, go to OFFER.
//   - No slot pending and IDLE_EN=0: stay.
//   - Latency: frame_valid rises on the edge after the SELECT cycle.
//  OFFER:
//   - frame_valid and frame_data are held stable until frame_valid&&frame_ready.
//   - enable falling does NOT withdraw the offer.
//   - On acceptance:
//     - frame_valid<=0 and frames_sent++.
//     - Slot frame: rep_cnt[sel]--, ptr<=sel. Idle frame: ptr unchanged.
//     - Then go to GAP with gap counter GAP_CYCLES-1, or to SELECT if GAP_CYCLES==0.
//  GAP: counter decrements once per cycle; at 0 go to SELECT.
//  Gap throughput:
//   - GAP_CYCLES=0: accept at cycle t, next frame_valid at t+2.
//   - GAP_CYCLES=G: next frame_valid at t+G+2.
//  Simultaneous events:
//   - slot_wr[sel] in the acceptance cycle: write wins, rep_cnt=REPEAT (no decrement),
//     new data is used at the next selection.
//   - slot_wr[sel] during OFFER before acceptance: the offered frame keeps the old data.
//   - Write to a slot that is not selected: no effect on the current offer.
//  Width rules: rep_cnt is 4 bits. Checksum is bytewise XOR.
//   frame_data[23:16]=addr, [15:8]=cmd, [7:0]=addr^cmd.
// STRUCTURE
//  Shared package dcc_pkg:
//   - DCC_IDLE_FRAME=24'hFF00FF, DCC_FRAME_W=24.
//   - FSM state encoding (SELECT=0, OFFER=1, GAP=2).
//  Sub-module dcc_rr_arbiter:
//   - Combinational priority search: req[N], ptr -> gnt_idx, gnt_any.
//   - Reused by a later multi-requester arbiter.
//  Top level: slot storage, rep counters, FSM, gap counter, output registers.
// TESTING
//  1. Reset release with IDLE_EN=1, enable=1, no writes, ready=1
//     -> frames 0xFF00FF with frame_is_idle=1, spaced GAP_CYCLES+2 cycles apart.
//  2. Write slot0 addr=0x03 cmd=0x74, REPEAT=3
//     -> exactly 3 frames of 0x037477, then idle frames; slot_pending[0] clears after the 3rd accept.
//  3. Slots 1 and 2 loaded in the same cycle (0x05/0x3F, 0x07/0x60)
//     -> alternate frames 0x053F3A, 0x076067, 0x053F3A, ...; frame_slot alternates 1,2.
//  4. Hold frame_ready=0 for 50 cycles during an offer, toggle enable=0
//     -> frame_valid and frame_data stable; after accept, no new frame while enable=0.
//  5. Rewrite slot0 (cmd=0x60) in the exact acceptance cycle
//     -> rep_cnt reloads to REPEAT; next slot0 frame is 0x036063.
//  6. Assert ARESETN=0 while frame_valid=1
//     -> all outputs 0 on the next edge; frames_sent=0; first slot serviced after release is slot0.

Source files
------------

// File: rtl/dcc_pkg.sv
// Shared DCC definitions: frame layout, idle packet and scheduler state encoding.
package dcc_pkg;

    localparam int unsigned DCC_BYTE_W  = 8;
    localparam int unsigned DCC_FRAME_W = 24;
    localparam int unsigned DCC_REP_W   = 4;

    localparam logic [DCC_FRAME_W-1:0] DCC_IDLE_FRAME = 24'hFF00FF;

    typedef enum logic [1:0] {
        ST_SELECT = 2'd0,
        ST_OFFER  = 2'd1,
        ST_GAP    = 2'd2
    } dcc_state_t;

    typedef struct packed {
        logic [DCC_BYTE_W-1:0] addr;
        logic [DCC_BYTE_W-1:0] cmd;
        logic [DCC_BYTE_W-1:0] chk;
    } dcc_frame_t;

    // Build a frame with its bytewise XOR checksum.
    function automatic dcc_frame_t dcc_make_frame(input logic [DCC_BYTE_W-1:0] addr,
                                                  input logic [DCC_BYTE_W-1:0] cmd);
        dcc_frame_t f;
        f.addr = addr;
        f.cmd  = cmd;
        f.chk  = addr ^ cmd;
        return f;
    endfunction

endpackage

// File: rtl/dcc_rr_arbiter.sv
// Combinational round-robin search: first asserted req after ptr, wrapping modulo N.
module dcc_rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    // Walk from the farthest candidate back to ptr+1 so the nearest hit wins.
    always_comb begin
        int idx;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = int'(N); k >= 1; k--) begin
            idx = (int'(ptr) + k) % int'(N);
            if (req[IDX_W'(idx)]) begin
                gnt_idx = IDX_W'(idx);
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcc_frame_scheduler.sv
// DCC frame scheduler: round-robin over command slots, repeat counting,
// checksum insertion, inter-packet gap and idle packet generation.
module dcc_frame_scheduler
    import dcc_pkg::*;
#(
    parameter int unsigned NUM_SLOTS  = 4,
    parameter int unsigned REPEAT     = 3,
    parameter int unsigned GAP_CYCLES = 100,
    parameter bit          IDLE_EN    = 1'b1,
    localparam int unsigned SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic                   enable,
    input  logic [NUM_SLOTS-1:0]   slot_wr,
    input  logic [DCC_BYTE_W-1:0]  slot_addr,
    input  logic [DCC_BYTE_W-1:0]  slot_cmd,
    output logic [NUM_SLOTS-1:0]   slot_pending,
    output logic                   frame_valid,
    input  logic                   frame_ready,
    output logic [DCC_FRAME_W-1:0] frame_data,
    output logic                   frame_is_idle,
    output logic [SLOT_W-1:0]      frame_slot,
    output logic [15:0]            frames_sent
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    dcc_state_t             state_q, state_d;
    logic [SLOT_W-1:0]      ptr_q, ptr_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [DCC_BYTE_W-1:0]  addr_q [NUM_SLOTS];
    logic [DCC_BYTE_W-1:0]  cmd_q  [NUM_SLOTS];
    logic [DCC_REP_W-1:0]   rep_q  [NUM_SLOTS];
    logic [DCC_REP_W-1:0]   rep_d  [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]   pending_d;
    logic                   valid_d;
    dcc_frame_t             data_d;
    logic                   idle_d;
    logic [SLOT_W-1:0]      slot_d;
    logic [15:0]            sent_d;
    logic [SLOT_W-1:0]      gnt_idx;
    logic                   gnt_any;

    // slot_pending always mirrors rep_q != 0, so it doubles as the request vector.
    dcc_rr_arbiter #(.N(NUM_SLOTS)) u_arb (
        .req     (slot_pending),
        .ptr     (ptr_q),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gap_d   = gap_q;
        rep_d   = rep_q;
        valid_d = frame_valid;
        data_d  = dcc_frame_t'(frame_data);
        idle_d  = frame_is_idle;
        slot_d  = frame_slot;
        sent_d  = frames_sent;

        case (state_q)
            ST_SELECT: begin
                if (enable) begin
                    if (gnt_any) begin
                        valid_d = 1'b1;
                        data_d  = dcc_make_frame(addr_q[gnt_idx], cmd_q[gnt_idx]);
                        idle_d  = 1'b0;
                        slot_d  = gnt_idx;
                        state_d = ST_OFFER;
                    end else if (IDLE_EN) begin
                        valid_d = 1'b1;
                        data_d  = dcc_frame_t'(DCC_IDLE_FRAME);
                        idle_d  = 1'b1;
                        slot_d  = '0;
                        state_d = ST_OFFER;
                    end
                end
            end
            ST_OFFER: begin
                if (frame_valid && frame_ready) begin
                    valid_d = 1'b0;
                    sent_d  = frames_sent + 16'd1;
                    if (!frame_is_idle) begin
                        rep_d[frame_slot] = rep_q[frame_slot] - DCC_REP_W'(1);
                        ptr_d             = frame_slot;
                    end
                    if (GAP_CYCLES == 0) begin
                        state_d = ST_SELECT;
                    end else begin
                        gap_d   = GAP_W'(GAP_CYCLES - 1);
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_SELECT;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = ST_SELECT;
        endcase

        // A load overrides any decrement in the same cycle.
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (slot_wr[i]) begin
                rep_d[i] = DCC_REP_W'(REPEAT);
            end
            pending_d[i] = (rep_d[i] != '0);
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q       <= ST_SELECT;
            ptr_q         <= SLOT_W'(NUM_SLOTS - 1);
            gap_q         <= '0;
            slot_pending  <= '0;
            frame_valid   <= 1'b0;
            frame_data    <= '0;
            frame_is_idle <= 1'b0;
            frame_slot    <= '0;
            frames_sent   <= '0;
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                rep_q[i]  <= '0;
                addr_q[i] <= '0;
                cmd_q[i]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            gap_q         <= gap_d;
            slot_pending  <= pending_d;
            frame_valid   <= valid_d;
            frame_data    <= data_d;
            frame_is_idle <= idle_d;
            frame_slot    <= slot_d;
            frames_sent   <= sent_d;
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                rep_q[i] <= rep_d[i];
                if (slot_wr[i]) begin
                    addr_q[i] <= slot_addr;
                    cmd_q[i]  <= slot_cmd;
                end
            end
        end
    end

endmodule
